tcb_lite_sub_mem: RTL
=====================

Name: tcb_lite_sub_mem

Overview:
- TCB-Lite subordinate endpoint: a synchronous byte-addressable memory that accepts requests and returns responses exactly DLY cycles after each transfer.
- Sits at the far end of a TCB-Lite link, as the responder for CPU instruction/data ports, interconnect leaf nodes and testbenches.
- Supports byte-enable mode and logarithmic-size mode, endianness swap, and error signalling for illegal accesses.

Parameters:
- DLY, 1, response delay in cycles; must be >=1. Elaboration error if 0.
- DAT, 32, data width; only 32 or 64 are legal.
- ADR, 32, address width.
- MOD, 1'b1, bus mode: 0 = logarithmic size, 1 = byte enable.
- HLD, 1'b0, hold the last response on rsp_* between responses.
- DEP, 1024, memory depth in DAT-wide words; power of 2.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-low
- vld  input  1  request valid
- rdy  output  1  request ready
- req_lck  input  1  arbitration lock; ignored
- req_ndn  input  1  endianness (0 = little, 1 = big); used only when MOD=0
- req_wen  input  1  write enable
- req_adr  input  ADR  byte address
- req_siz  input  SIZ  log2 transfer size, SIZ=$clog2($clog2(DAT/8)+1); used only when MOD=0
- req_byt  input  DAT/8  byte enables; used only when MOD=1
- req_wdt  input  DAT  write data
- rsp_vld  output  1  response strobe, high in the response cycle
- rsp_rdt  output  DAT  read data
- rsp_err  output  1  bus error

Behaviour:
- Definitions: trn = vld & rdy. BYT = DAT/8. MAX = log2(BYT). off = req_adr[MAX-1:0]. idx = req_adr[MAX+:log2(DEP)].
- Reset (rst=0, async assert, sync deassert):
  - rdy=0, rsp_vld=0, rsp_rdt=0, rsp_err=0.
  - All pipeline stage valid bits cleared; in-flight responses are discarded.
  - Memory contents are not reset.
- Ready: rdy=1 from the first clk edge after reset release. No backpressure otherwise; one transfer per cycle is sustained.
- Error detection, evaluated at trn:
  - err=1 if req_adr >= DEP*BYT.
  - MOD=0: err=1 also if req_siz > MAX, or if off is not a multiple of 2**req_siz.
  - MOD=1: req_byt=0 is legal; it produces no write and read data 0.
  - An errored write does not modify memory. An errored read returns rdt=0.
- Write, MOD=1: in the trn cycle, each byte lane i with req_byt[i]=1 writes req_wdt[8i+:8] to mem[idx].
- Write, MOD=0:
  - Transfer bytes are req_wdt[0 .. 2**siz-1], right-aligned.
  - If ndn=1, byte order is reversed within the 2**siz bytes.
  - Bytes are rotated left by off lanes, and lanes off .. off+2**siz-1 are written.
- Read data:
  - Sampled from mem[idx] in the trn cycle, after any same-cycle write is excluded.
  - A read at cycle N+1 observes a write completed at cycle N.
  - MOD=1: the full word is returned; the manager masks it.
  - MOD=0: the word is rotated right by off. Lanes >= 2**siz are zeroed. If ndn=1, byte order is reversed within 2**siz bytes.
- Response timing:
  - A trn at edge N produces rsp_vld=1 with rsp_rdt/rsp_err valid in the cycle after edge N+DLY.
  - Writes also produce a response (rdt=0, err per the error rules).
  - Back-to-back transfers produce back-to-back responses in order.
- Between responses:
  - HLD=0: rsp_rdt=0, rsp_err=0.
  - HLD=1: the last response values are held.
- rsp_vld is never high in the DLY cycles following reset release.

Decomposition:
- tcb_lite_pkg gains:
  - tcb_mod_t enum {TCB_LOG=0, TCB_BYT=1}
  - functions siz2byt(siz), byte_swap(data, siz) and rotate(data, off)
- Sub-module tcb_lite_rsp_pipe (parameters DLY, HLD, DAT): a DLY-stage shift register of {vld, rdt, err} with the async active-low clear. Registers load only when the incoming stage is valid.

Test Plan:
- Reset/ready, DLY=2: assert rst=0, then release → rdy=0 until the first edge after release, then rdy=1. rsp_vld stays 0 for 2 cycles.
- MOD=1 sequence, DLY=1:
  - Write adr=0x10, byt=4'b0101, wdt=0xAABBCCDD.
  - Next cycle, read adr=0x10 → rsp_rdt=0x00BB00DD one cycle after the read transfer, err=0.
  - The write response is rsp_vld=1, rdt=0.
- MOD=0 halfword, big-endian, starting from memory word 0:
  - Write adr=0x2, siz=1, ndn=1, wdt=0x1234.
  - Read adr=0x0, siz=2, ndn=0 → rdt=0x34120000.
  - Read adr=0x2, siz=1, ndn=1 → rdt=0x00001234.
- Errors, DEP=1024, DAT=32:
  - adr=0x1000 → err=1, rdt=0, memory unchanged.
  - MOD=0, adr=0x1, siz=1 → err=1.
  - MOD=0, siz=3 → err=1.
- Pipelining, DLY=3: 8 consecutive reads of preloaded words → 8 consecutive rsp_vld cycles starting 3 cycles after the first transfer, data in order.
- Reset mid-flight, DLY=3: issue 2 reads, assert rst after 1 cycle → no rsp_vld ever emitted for those reads. A post-reset read returns correctly.

Source files
------------

// File: rtl/tcb_lite_pkg.sv
// TCB-Lite shared types and byte-lane helpers.
// Helpers work on a 64-bit container; callers zero-extend and truncate to DAT.
package tcb_lite_pkg;

   localparam int unsigned DW_MAX = 64;

   typedef logic [DW_MAX-1:0] dword_t;

   typedef enum logic {
      TCB_LOG = 1'b0,
      TCB_BYT = 1'b1
   } tcb_mod_t;

   // Number of bytes in a transfer of log2 size siz.
   function automatic logic [3:0] siz2byt(input logic [1:0] siz);
      return 4'(4'd1 << siz);
   endfunction

   // Reverse byte order within the low 2**siz bytes; upper bytes pass through.
   function automatic dword_t byte_swap(input dword_t data, input logic [1:0] siz);
      dword_t r;
      int     n;
      r = data;
      n = int'(siz2byt(siz));
      for (int i = 0; i < 8; i++) begin
         if (i < n) r[8*i +: 8] = data[8*(n-1-i) +: 8];
      end
      return r;
   endfunction

   // Rotate the low byt bytes left by off lanes (byt is a power of two).
   function automatic dword_t rotate(input dword_t data, input logic [2:0] off, input logic [3:0] byt);
      dword_t r;
      int     j;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         j = (i + int'(off)) & (int'(byt) - 1);
         if (i < int'(byt)) r[8*j +: 8] = data[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/tcb_lite_rsp_pipe.sv
// Response delay line: DLY stages of {vld, rdt, err}.
// Ports: clk, rst (async active-low), in_* stage input, out_* last stage.
// Data registers load only when the incoming stage is valid; with HLD=0 the
// last stage clears its data when idle so the bus reads zero between responses.
module tcb_lite_rsp_pipe #(
   parameter int unsigned DLY = 1,
   parameter bit          HLD = 1'b0,
   parameter int unsigned DAT = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_vld,
   input  logic [DAT-1:0] in_rdt,
   input  logic           in_err,
   output logic           out_vld,
   output logic [DAT-1:0] out_rdt,
   output logic           out_err
);

   logic           vld_q [DLY];
   logic [DAT-1:0] rdt_q [DLY];
   logic           err_q [DLY];

   for (genvar s = 0; s < DLY; s++) begin : g_stg
      logic           src_vld;
      logic [DAT-1:0] src_rdt;
      logic           src_err;

      if (s == 0) begin : g_head
         assign src_vld = in_vld;
         assign src_rdt = in_rdt;
         assign src_err = in_err;
      end else begin : g_body
         assign src_vld = vld_q[s-1];
         assign src_rdt = rdt_q[s-1];
         assign src_err = err_q[s-1];
      end

      // One pipeline stage.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            vld_q[s] <= 1'b0;
            rdt_q[s] <= '0;
            err_q[s] <= 1'b0;
         end else begin
            vld_q[s] <= src_vld;
            if (src_vld) begin
               rdt_q[s] <= src_rdt;
               err_q[s] <= src_err;
            end else if (!HLD && (s == int'(DLY) - 1)) begin
               rdt_q[s] <= '0;
               err_q[s] <= 1'b0;
            end
         end
      end
   end

   assign out_vld = vld_q[DLY-1];
   assign out_rdt = rdt_q[DLY-1];
   assign out_err = err_q[DLY-1];

endmodule

// File: rtl/tcb_lite_sub_mem.sv
// TCB-Lite subordinate memory: byte-addressable RAM answering every transfer
// exactly DLY cycles later, in byte-enable (MOD=1) or log-size (MOD=0) mode.
// Ports: clk, rst (async active-low); vld/rdy handshake; req_* request fields
// (req_lck ignored); rsp_vld/rsp_rdt/rsp_err registered response.
module tcb_lite_sub_mem
   import tcb_lite_pkg::*;
#(
   parameter int unsigned DLY = 1,
   parameter int unsigned DAT = 32,
   parameter int unsigned ADR = 32,
   parameter logic        MOD = 1'b1,
   parameter logic        HLD = 1'b0,
   parameter int unsigned DEP = 1024,
   localparam int unsigned BYT = DAT / 8,
   localparam int unsigned SIZ = $clog2($clog2(DAT/8) + 1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           vld,
   output logic           rdy,
   input  logic           req_lck,
   input  logic           req_ndn,
   input  logic           req_wen,
   input  logic [ADR-1:0] req_adr,
   input  logic [SIZ-1:0] req_siz,
   input  logic [BYT-1:0] req_byt,
   input  logic [DAT-1:0] req_wdt,
   output logic           rsp_vld,
   output logic [DAT-1:0] rsp_rdt,
   output logic           rsp_err
);

   localparam int unsigned MAX  = $clog2(BYT);
   localparam int unsigned IDXW = $clog2(DEP);
   localparam int unsigned AW   = MAX + IDXW;

   if (DLY < 1) begin : g_bad_dly
      $error("tcb_lite_sub_mem: DLY must be >= 1");
   end
   if (DAT != 32 && DAT != 64) begin : g_bad_dat
      $error("tcb_lite_sub_mem: DAT must be 32 or 64");
   end
   if (DEP < 2 || (DEP & (DEP - 1)) != 0) begin : g_bad_dep
      $error("tcb_lite_sub_mem: DEP must be a power of 2");
   end

   logic [DAT-1:0]  mem [DEP];
   logic            trn;
   logic [MAX-1:0]  off;
   logic [IDXW-1:0] idx;
   logic [DAT-1:0]  mem_rd;
   logic            adr_err;
   logic [3:0]      n_c;
   dword_t          wtmp;
   dword_t          rtmp;
   logic [BYT-1:0]  wbe;
   logic [DAT-1:0]  wdat;
   logic [DAT-1:0]  rdat;
   logic            err;
   logic            unused_lck;

   assign unused_lck = req_lck;
   assign trn        = vld & rdy;
   assign off        = req_adr[MAX-1:0];
   assign idx        = req_adr[MAX +: IDXW];
   assign mem_rd     = mem[idx];

   // Any address bit above the memory span is out of range.
   if (ADR > AW) begin : g_adr_hi
      assign adr_err = |req_adr[ADR-1:AW];
   end else begin : g_adr_fit
      assign adr_err = 1'b0;
   end

   // Ready rises on the first edge after reset release and stays high.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rdy <= 1'b0;
      else      rdy <= 1'b1;
   end

   // Lane mapping, error checks and read-data formatting.
   always_comb begin
      n_c  = siz2byt(2'(req_siz));
      wtmp = DW_MAX'(req_wdt);
      rtmp = '0;
      wbe  = '0;
      wdat = '0;
      rdat = '0;
      err  = adr_err;
      if (tcb_mod_t'(MOD) == TCB_LOG) begin
         if ((int'(req_siz) > int'(MAX)) || ((int'(off) & (int'(n_c) - 1)) != 0)) err = 1'b1;
         if (req_ndn) wtmp = byte_swap(wtmp, 2'(req_siz));
         wdat = DAT'(rotate(wtmp, 3'(off), 4'(BYT)));
         for (int i = 0; i < int'(BYT); i++) begin
            wbe[i] = (i >= int'(off)) && (i < int'(off) + int'(n_c));
         end
         // Right rotation by off expressed as a left rotation by BYT-off.
         rtmp = rotate(DW_MAX'(mem_rd), 3'(int'(BYT) - int'(off)), 4'(BYT));
         for (int i = 0; i < 8; i++) begin
            if (i >= int'(n_c)) rtmp[8*i +: 8] = 8'h00;
         end
         if (req_ndn) rtmp = byte_swap(rtmp, 2'(req_siz));
         rdat = DAT'(rtmp);
      end else begin
         wbe  = req_byt;
         wdat = req_wdt;
         rdat = (req_byt == '0) ? '0 : mem_rd;
      end
      if (err) wbe = '0;
      if (err || req_wen) rdat = '0;
   end

   // Storage is not reset; only transfers touch it.
   always_ff @(posedge clk) begin
      if (trn && req_wen) begin
         for (int i = 0; i < int'(BYT); i++) begin
            if (wbe[i]) mem[idx][8*i +: 8] <= wdat[8*i +: 8];
         end
      end
   end

   tcb_lite_rsp_pipe #(
      .DLY (DLY),
      .HLD (HLD),
      .DAT (DAT)
   ) u_rsp_pipe (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (trn),
      .in_rdt  (rdat),
      .in_err  (err),
      .out_vld (rsp_vld),
      .out_rdt (rsp_rdt),
      .out_err (rsp_err)
   );

endmodule
